// File: rtl/next_instr_adr_if.sv
// next_instr_adr_if: redirect/stall inputs and PregInstrAdr outputs of the next-address unit
interface next_instr_adr_if #(parameter int WORD_LENGTH = 32);
  logic inStall;
  logic inBrTaken;
  logic [WORD_LENGTH-1:0] inBrP;
  logic [WORD_LENGTH-1:0] inBrO;
  logic inTrap;
  logic [WORD_LENGTH-1:0] inTrapO;
  logic [WORD_LENGTH-1:0] outP;
  logic [WORD_LENGTH-1:0] outO;
  logic outValid;
  logic outMisalign;
  modport master (
    output inStall, inBrTaken, inBrP, inBrO, inTrap, inTrapO,
    input  outP, outO, outValid, outMisalign
  );
  modport slave (
    input  inStall, inBrTaken, inBrP, inBrO, inTrap, inTrapO,
    output outP, outO, outValid, outMisalign
  );
endinterface

// File: rtl/next_instr_adr_unit.sv
// next_instr_adr_unit: selects reset/trap/branch/sequential next fetch address, buffering one redirect across stalls
module next_instr_adr_unit #(
  parameter int WORD_LENGTH = 32,
  parameter logic [WORD_LENGTH-1:0] RESET_P = '0,
  parameter logic [WORD_LENGTH-1:0] RESET_O = '0,
  parameter logic [WORD_LENGTH-1:0] TRAP_P = '0,
  parameter int INSTR_BYTES = 4
) (
  input logic clk,
  input logic rst,
  next_instr_adr_if.slave bus
);
  localparam int W = WORD_LENGTH;
  typedef enum logic [1:0] {S_RESET, S_RUN, S_STALL} state_t;
  state_t state, state_nx;
  logic [W-1:0] p, p_nx, o, o_nx, pend_p, pend_p_nx, pend_o, pend_o_nx;
  logic valid, valid_nx, mis, mis_nx;
  logic pend_valid, pend_valid_nx, pend_trap, pend_trap_nx, pend_mis, pend_mis_nx;
  logic in_redir, in_mis;
  logic [W-1:0] in_p, in_o, in_o_al;
  always_comb begin
    in_redir = bus.inTrap | bus.inBrTaken;
    in_p = bus.inTrap ? TRAP_P : bus.inBrP;
    in_o = bus.inTrap ? bus.inTrapO : bus.inBrO;
    in_mis = |in_o[1:0];
    in_o_al = {in_o[W-1:2], 2'b00};
    state_nx = state;
    p_nx = p;
    o_nx = o;
    valid_nx = valid;
    mis_nx = 1'b0;
    pend_valid_nx = pend_valid;
    pend_trap_nx = pend_trap;
    pend_p_nx = pend_p;
    pend_o_nx = pend_o;
    pend_mis_nx = pend_mis;
    if (state == S_RESET) begin
      state_nx = S_RUN;
      valid_nx = 1'b1;
    end else if (bus.inStall) begin
      state_nx = S_STALL;
      // a pending trap may only be displaced by another trap
      if (bus.inTrap | (bus.inBrTaken & ~(pend_valid & pend_trap))) begin
        pend_valid_nx = 1'b1;
        pend_trap_nx = bus.inTrap;
        pend_p_nx = in_p;
        pend_o_nx = in_o_al;
        pend_mis_nx = in_mis;
      end
    end else begin
      state_nx = S_RUN;
      if (in_redir | pend_valid) begin
        p_nx = in_redir ? in_p : pend_p;
        o_nx = in_redir ? in_o_al : pend_o;
        mis_nx = in_redir ? in_mis : pend_mis;
        pend_valid_nx = 1'b0;
      end else
        o_nx = o + W'(INSTR_BYTES);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RESET;
      p <= RESET_P;
      o <= RESET_O;
      valid <= 1'b0;
      mis <= 1'b0;
      pend_valid <= 1'b0;
      pend_trap <= 1'b0;
      pend_p <= '0;
      pend_o <= '0;
      pend_mis <= 1'b0;
    end else begin
      state <= state_nx;
      p <= p_nx;
      o <= o_nx;
      valid <= valid_nx;
      mis <= mis_nx;
      pend_valid <= pend_valid_nx;
      pend_trap <= pend_trap_nx;
      pend_p <= pend_p_nx;
      pend_o <= pend_o_nx;
      pend_mis <= pend_mis_nx;
    end
  end
  assign bus.outP = p;
  assign bus.outO = o;
  assign bus.outValid = valid;
  assign bus.outMisalign = mis;
endmodule
